wb_collect: RTL and testbench
=============================

Name: wb_collect

Overview:
- Writeback collector: the consuming end of the execution-unit writeback interface.
- Accepts up to three writeback streams per cycle: int0 mul, int0 alu, int1 alu. Each stream carries valid, need_to_wb, prd, robid and data.
- Drives two registered physical-register-file write / ROB-complete / wakeup ports.
- Sources have no backpressure, so excess results are held in an age-ordered overflow FIFO. The block gives the issue stage an early stall and squashes younger entries on flush.

Parameters:
- PRF_WIDTH, from common, physical register index width.
- ROB_WIDTH, from common, ROB index width; robid is ROB_WIDTH+1 bits, the MSB is the wrap bit.
- BUF_DEPTH, 8, overflow FIFO entries, power of two.
- STALL_SLACK, 3, free entries reserved for results already in flight when issue_stall rises.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush_valid  in  1  branch/exception flush this cycle
- flush_robid  in  ROB_WIDTH+1  flushing instruction; strictly younger results are killed
- wb_valid  in  3  per-source valid; [0]=mul, [1]=int0 alu, [2]=int1 alu
- wb_need_to_wb  in  3  per-source PRF write required
- wb_prd  in  3xPRF_WIDTH  per-source destination preg
- wb_robid  in  3x(ROB_WIDTH+1)  per-source ROB id
- wb_data  in  3x32  per-source result
- out_valid  out  2  port completes an instruction to the ROB
- out_we  out  2  PRF write enable (out_valid & need_to_wb)
- out_prd  out  2xPRF_WIDTH
- out_robid  out  2x(ROB_WIDTH+1)
- out_data  out  2x32
- issue_stall  out  1  stop issuing into int0/int1
- overflow_err  out  1  sticky; an arrival was lost for lack of space

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs 0; FIFO empty (head = tail = count = 0); entry valid bits 0; overflow_err 0.
  - Reset mid-operation discards every buffered and in-flight result.
- Younger test, same as the execution units: younger(r) = r[MSB] ^ flush_robid[MSB] ^ (r[MSB-1:0] > flush_robid[MSB-1:0]).
- Normal cycle (flush_valid = 0):
  - Candidate order: FIFO entries from head in arrival order, then current inputs src0, src1, src2.
  - The first two valid candidates load out[0] and out[1] at the clock edge, so minimum latency is 1 cycle.
  - Killed FIFO entries (valid bit 0) at head are popped without using a port. At most 2 pops total per cycle, killed or not.
  - Unselected valid inputs are pushed at tail in src order. Push and pop occur in the same cycle; count += pushes − pops.
  - Unused out ports register out_valid = 0, out_we = 0; payload is don't-care.
- Flush cycle (flush_valid = 1):
  - All inputs are ignored. Sources already mask their valid during flush.
  - No pops; both out_valid and out_we register 0.
  - Every FIFO entry with younger(robid) has its valid bit cleared. Occupancy is unchanged; bubbles drain later.
  - Output registers currently holding younger results are not recalled. They are cleared by the same edge because the ports register 0.
- Full:
  - If pushes exceed BUF_DEPTH − count + pops, the excess arrivals (highest src index first) are dropped and overflow_err sets until reset.
  - Pointers never pass each other.
- issue_stall: registered, equal to (count_next > BUF_DEPTH − STALL_SLACK − 3). It deasserts the cycle after count_next falls to or below the threshold.
- Wrap-around: head and tail are log2(BUF_DEPTH) bits plus an extra wrap bit; full when the low bits are equal and the wrap bits differ.
- need_to_wb = 0 results still occupy a port with out_valid = 1, out_we = 0 (ROB completion only).

Decomposition:
- common: wb_entry_t struct {need_to_wb, prd, robid, data}. Add the is_younger(robid, flush_robid) function so it is shared with the execution units.
- Sub-module wb_buf: a multi-push (≤3) / multi-pop (≤2) circular FIFO with per-entry valid and a flush-kill input.
- wb_collect holds the selection logic, output registers, stall and error logic.

Test Plan:
- Single alu result, src1, robid 5, prd 12, data 0xDEAD → next cycle out_valid = 01, out_we = 01, out_prd[0] = 12; FIFO count stays 0.
- Three results in one cycle, robids 3, 4, 7 on src0..2 → cycle+1: ports carry robids 3 and 4; src2 buffered. Cycle+2: out[0] = robid 7, out_valid = 01.
- Continuous 3/cycle for 6 cycles (net +1 per cycle) → issue_stall rises when count_next > 2. No overflow_err if issue stops; all 18 results exit in arrival order.
- Buffer robids 6, 9, 12, then flush_robid = 8 (same wrap) → 9 and 12 are killed. Next cycles output only 6, and count drains to 0 within 2 cycles.
- Wrap compare: FIFO entry robid {1,2}, flush_robid {0,30} → entry is younger and killed. Entry robid {0,29} survives.
- Force BUF_DEPTH full, then 3 arrivals with no free ports → overflow_err = 1 and stays 1 until reset. Assert reset mid-drain → all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/wb_collect_pkg.sv
// wb_collect_pkg: shared writeback widths, the buffered entry type and the
// ROB-age compare used by the collector and the execution units.
package wb_collect_pkg;
    localparam int PRF_WIDTH = 6;
    localparam int ROB_WIDTH = 5;

    typedef struct packed {
        logic                 need_to_wb;
        logic [PRF_WIDTH-1:0] prd;
        logic [ROB_WIDTH:0]   robid;
        logic [31:0]          data;
    } wb_entry_t;

    // MSB of a robid is the wrap bit, so a differing wrap inverts the index compare.
    function automatic logic is_younger(input logic [ROB_WIDTH:0] r, input logic [ROB_WIDTH:0] f);
        return r[ROB_WIDTH] ^ f[ROB_WIDTH] ^ (r[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]);
    endfunction
endpackage

// File: rtl/wb_buf.sv
// wb_buf: circular overflow FIFO taking up to 3 pushes and 2 pops per cycle,
// with a per-entry valid bit that a flush clears for younger results.
module wb_buf
    import wb_collect_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_valid,
    input  logic [ROB_WIDTH:0]     flush_robid,
    input  logic [1:0]             push_cnt,
    input  wb_entry_t [2:0]        push_entry,
    input  logic [1:0]             pop_cnt,
    output wb_entry_t [1:0]        head_entry,
    output logic [1:0]             head_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW:0]      head;
    logic [AW:0]      tail;

    // Pointers carry an extra wrap bit, so the plain difference is the occupancy.
    assign count = tail - head;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            head_entry[i] = mem[head[AW-1:0] + AW'(i)];
            head_valid[i] = vld[head[AW-1:0] + AW'(i)] && int'(count) > i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (i < int'(push_cnt)) mem[tail[AW-1:0] + AW'(i)] <= push_entry[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            vld  <= '0;
        end else begin
            for (int d = 0; d < DEPTH; d++)
                if (flush_valid && is_younger(mem[d].robid, flush_robid)) vld[d] <= 1'b0;
            for (int i = 0; i < 3; i++)
                if (i < int'(push_cnt)) vld[tail[AW-1:0] + AW'(i)] <= 1'b1;
            head <= head + (AW+1)'(pop_cnt);
            tail <= tail + (AW+1)'(push_cnt);
        end
    end
endmodule

// File: rtl/wb_collect.sv
// wb_collect: merges three unthrottled writeback streams onto two registered
// PRF/ROB ports, buffering the excess in age order and squashing on flush.
module wb_collect
    import wb_collect_pkg::*;
#(
    parameter int BUF_DEPTH   = 8,
    parameter int STALL_SLACK = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_valid,
    input  logic [ROB_WIDTH:0]        flush_robid,
    input  logic [2:0]                wb_valid,
    input  logic [2:0]                wb_need_to_wb,
    input  logic [2:0][PRF_WIDTH-1:0] wb_prd,
    input  logic [2:0][ROB_WIDTH:0]   wb_robid,
    input  logic [2:0][31:0]          wb_data,
    output logic [1:0]                out_valid,
    output logic [1:0]                out_we,
    output logic [1:0][PRF_WIDTH-1:0] out_prd,
    output logic [1:0][ROB_WIDTH:0]   out_robid,
    output logic [1:0][31:0]          out_data,
    output logic                      issue_stall,
    output logic                      overflow_err
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    wb_entry_t [2:0] src;
    wb_entry_t [2:0] push_entry;
    wb_entry_t [1:0] head_entry;
    wb_entry_t [1:0] sel;
    logic [1:0]      head_valid;
    logic [1:0]      sel_v;
    logic [1:0]      pop_cnt;
    logic [1:0]      push_cnt;
    logic [1:0]      n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            lost;

    wb_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_valid(flush_valid),
        .flush_robid(flush_robid),
        .push_cnt   (push_cnt),
        .push_entry (push_entry),
        .pop_cnt    (pop_cnt),
        .head_entry (head_entry),
        .head_valid (head_valid),
        .count      (count)
    );

    always_comb begin
        for (int i = 0; i < 3; i++)
            src[i] = '{need_to_wb: wb_need_to_wb[i], prd: wb_prd[i], robid: wb_robid[i], data: wb_data[i]};
    end

    // Inputs may take a port only once every buffered entry has been popped,
    // otherwise a newer result would overtake an older buffered one.
    always_comb begin
        sel        = '0;
        sel_v      = '0;
        pop_cnt    = '0;
        push_cnt   = '0;
        push_entry = '0;
        lost       = 1'b0;
        n          = '0;
        if (!flush_valid) begin
            for (int i = 0; i < 2; i++)
                if (int'(count) > i) begin
                    pop_cnt = pop_cnt + 2'd1;
                    if (head_valid[i]) begin
                        sel[n[0]]   = head_entry[i];
                        sel_v[n[0]] = 1'b1;
                        n           = n + 2'd1;
                    end
                end
            for (int i = 0; i < 3; i++)
                if (wb_valid[i]) begin
                    if (!n[1] && int'(count) == int'(pop_cnt)) begin
                        sel[n[0]]   = src[i];
                        sel_v[n[0]] = 1'b1;
                        n           = n + 2'd1;
                    end else if (int'(count) - int'(pop_cnt) + int'(push_cnt) < BUF_DEPTH) begin
                        push_entry[push_cnt] = src[i];
                        push_cnt             = push_cnt + 2'd1;
                    end else begin
                        lost = 1'b1;
                    end
                end
        end
    end

    assign count_next = count - CW'(pop_cnt) + CW'(push_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= '0;
            out_we       <= '0;
            out_prd      <= '0;
            out_robid    <= '0;
            out_data     <= '0;
            issue_stall  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            out_valid <= sel_v;
            for (int p = 0; p < 2; p++) begin
                out_we[p]    <= sel_v[p] & sel[p].need_to_wb;
                out_prd[p]   <= sel[p].prd;
                out_robid[p] <= sel[p].robid;
                out_data[p]  <= sel[p].data;
            end
            issue_stall  <= int'(count_next) > BUF_DEPTH - STALL_SLACK - 3;
            overflow_err <= overflow_err | lost;
        end
    end
endmodule

// File: tb/tb_wb_collect.sv
// tb_wb_collect: scoreboard bench for the writeback collector; expected
// results are queued as they are driven and matched as the ports fire.
module tb_wb_collect;
    import wb_collect_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush_valid = 1'b0;
    logic [ROB_WIDTH:0]        flush_robid = '0;
    logic [2:0]                wb_valid = '0;
    logic [2:0]                wb_need_to_wb = '0;
    logic [2:0][PRF_WIDTH-1:0] wb_prd = '0;
    logic [2:0][ROB_WIDTH:0]   wb_robid = '0;
    logic [2:0][31:0]          wb_data = '0;
    logic [1:0]                out_valid;
    logic [1:0]                out_we;
    logic [1:0][PRF_WIDTH-1:0] out_prd;
    logic [1:0][ROB_WIDTH:0]   out_robid;
    logic [1:0][31:0]          out_data;
    logic                      issue_stall;
    logic                      overflow_err;

    typedef struct {
        logic                 we;
        logic [PRF_WIDTH-1:0] prd;
        logic [ROB_WIDTH:0]   robid;
        logic [31:0]          data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_on = 1'b1;
    int   stall_up[6] = '{0, 0, 1, 1, 1, 1};
    int   stall_dn[3] = '{1, 0, 0};

    wb_collect dut (
        .clk          (clk),
        .reset        (reset),
        .flush_valid  (flush_valid),
        .flush_robid  (flush_robid),
        .wb_valid     (wb_valid),
        .wb_need_to_wb(wb_need_to_wb),
        .wb_prd       (wb_prd),
        .wb_robid     (wb_robid),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_we       (out_we),
        .out_prd      (out_prd),
        .out_robid    (out_robid),
        .out_data     (out_data),
        .issue_stall  (issue_stall),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Younger means a nonzero forward distance of less than half the robid space.
    function automatic bit young(logic [ROB_WIDTH:0] r, logic [ROB_WIDTH:0] f);
        logic [ROB_WIDTH:0] d;
        d = r - f;
        return d != 0 && int'(d) < (1 << ROB_WIDTH);
    endfunction

    task automatic drive(int s, bit need, int prd, int rid);
        exp_t e;
        wb_valid[s]      = 1'b1;
        wb_need_to_wb[s] = need;
        wb_prd[s]        = PRF_WIDTH'(prd);
        wb_robid[s]      = (ROB_WIDTH+1)'(rid);
        wb_data[s]       = $urandom;
        e = '{need, wb_prd[s], wb_robid[s], wb_data[s]};
        if (sb_on) sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        wb_valid    = '0;
        flush_valid = 1'b0;
        check("port_order", 64'(out_valid == 2'b10), 0);
        for (int p = 0; p < 2; p++) begin
            check("we_gate", 64'(out_we[p] & ~out_valid[p]), 0);
            if (out_valid[p] && sb_on) begin
                if (sb.size() == 0) begin
                    check("extra_valid", 64'(out_valid[p]), 0);
                end else begin
                    e = sb.pop_front();
                    check("robid", 64'(out_robid[p]), 64'(e.robid));
                    check("prd", 64'(out_prd[p]), 64'(e.prd));
                    check("data", 64'(out_data[p]), 64'(e.data));
                    check("we", 64'(out_we[p]), 64'(e.we));
                end
            end
        end
    endtask

    task automatic flush(int rid);
        exp_t keep[$];
        flush_valid = 1'b1;
        flush_robid = (ROB_WIDTH+1)'(rid);
        foreach (sb[i]) if (!young(sb[i].robid, flush_robid)) keep.push_back(sb[i]);
        sb = keep;
        step();
        check("flush_out", 64'(out_valid), 0);
    endtask

    // Two filler cycles leave two entries buffered, so all three targets land in the FIFO.
    task automatic buffer3(int a, int b, int c);
        drive(0, 1, 1, 40); drive(1, 1, 2, 41); drive(2, 1, 3, 42);
        step();
        drive(0, 1, 4, 43); drive(1, 1, 5, 44); drive(2, 1, 6, 45);
        step();
        drive(0, 1, 7, a); drive(1, 1, 8, b); drive(2, 1, 9, c);
        step();
    endtask

    initial begin
        #12;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_we", 64'(out_we), 0);
        check("rst_stall", 64'(issue_stall), 0);
        check("rst_ovf", 64'(overflow_err), 0);
        reset = 1'b0;

        drive(1, 1, 12, 5);
        step();
        check("t1_valid", 64'(out_valid), 64'(2'b01));
        check("t1_we", 64'(out_we), 64'(2'b01));
        check("t1_prd", 64'(out_prd[0]), 12);
        step();
        check("t1_idle", 64'(out_valid), 0);

        drive(0, 0, 3, 20);
        step();
        check("nwb_valid", 64'(out_valid), 64'(2'b01));
        check("nwb_we", 64'(out_we), 0);

        drive(0, 1, 1, 3); drive(1, 1, 2, 4); drive(2, 1, 3, 7);
        step();
        check("t2_both", 64'(out_valid), 64'(2'b11));
        step();
        check("t2_one", 64'(out_valid), 64'(2'b01));
        check("t2_rid", 64'(out_robid[0]), 7);
        step();
        check("t2_idle", 64'(out_valid), 0);

        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 3; s++) drive(s, (k + s) % 2, k * 3 + s, 10 + k * 3 + s);
            step();
            check("stall_up", 64'(issue_stall), 64'(stall_up[k]));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_dn", 64'(issue_stall), 64'(stall_dn[k]));
        end
        check("burst_ovf", 64'(overflow_err), 0);
        check("burst_drain", 64'(sb.size()), 0);

        buffer3(6, 9, 12);
        flush(8);
        step();
        check("kill_one", 64'(out_valid), 64'(2'b01));
        step();
        check("kill_empty", 64'(out_valid), 0);
        check("kill_sb", 64'(sb.size()), 0);

        buffer3(34, 29, 35);
        flush(30);
        step();
        check("wrap_one", 64'(out_valid), 64'(2'b01));
        check("wrap_rid", 64'(out_robid[0]), 29);
        step();
        check("wrap_empty", 64'(out_valid), 0);
        check("wrap_sb", 64'(sb.size()), 0);

        sb_on = 1'b0;
        for (int k = 0; k < 9; k++) begin
            for (int s = 0; s < 3; s++) drive(s, 1, s, k * 3 + s);
            step();
            if (k == 7) check("ovf_pre", 64'(overflow_err), 0);
        end
        check("ovf_set", 64'(overflow_err), 1);
        step();
        check("ovf_sticky", 64'(overflow_err), 1);
        check("ovf_drain", 64'(out_valid), 64'(2'b11));
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 0);
        check("arst_we", 64'(out_we), 0);
        check("arst_ovf", 64'(overflow_err), 0);
        check("arst_stall", 64'(issue_stall), 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst", 64'(out_valid), 0);
        step();
        check("post_rst2", 64'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
